// File: rtl/bit_scan_encoder.sv
// Multi-hot to binary encoder: drains every set bit of an accepted request
// vector as one index per ready/valid beat, lowest- or highest-first.
module bit_scan_encoder #(
    parameter int WIDTH = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int ADDR_WIDTH = $clog2(WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [WIDTH-1:0]      iv_input,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [ADDR_WIDTH-1:0] ov_addr,
    output logic                  o_last,
    output logic                  o_zero
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        pend_q, pend_d;
    logic                    zero_q, zero_d;

    logic                    found;
    logic [ADDR_WIDTH-1:0]   scan_idx;
    logic [WIDTH-1:0]        scan_oh;
    logic [WIDTH-1:0]        pend_rest;

    // Priority pick of the next pending bit in the configured order
    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        scan_oh  = '0;
        if (MSB_FIRST) begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (!found && pend_q[i]) begin
                    found      = 1'b1;
                    scan_idx   = ADDR_WIDTH'(i);
                    scan_oh[i] = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!found && pend_q[i]) begin
                    found      = 1'b1;
                    scan_idx   = ADDR_WIDTH'(i);
                    scan_oh[i] = 1'b1;
                end
            end
        end
    end

    // Only one bit left iff clearing the selected one empties the register
    assign pend_rest = pend_q & ~scan_oh;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        zero_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    if (|iv_input) begin
                        pend_d  = iv_input;
                        state_d = SCAN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            SCAN: begin
                if (i_ready) begin
                    pend_d = pend_rest;
                    if (pend_rest == '0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            zero_q  <= zero_d;
        end
    end

    assign o_ready = (state_q == IDLE) && !i_rst;
    assign o_valid = (state_q == SCAN);
    assign ov_addr = (state_q == SCAN) ? scan_idx : '0;
    assign o_last  = (state_q == SCAN) && (pend_rest == '0);
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_bit_scan_encoder.sv
// Directed bench for bit_scan_encoder: three instances (5-bit LSB-first,
// 5-bit MSB-first, 8-bit LSB-first) driven from a vector table.
module tb_bit_scan_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [2:0]      vin;
    logic [7:0]      iv;
    logic            rdy;
    logic [2:0]      ord;
    logic [2:0]      ov;
    logic [2:0]      olast;
    logic [2:0]      ozero;
    logic [2:0][2:0] addr;

    int total = 0;
    int bad = 0;

    bit_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b0)) u0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[0]), .o_ready(ord[0]),
        .iv_input(iv[4:0]), .o_valid(ov[0]), .i_ready(rdy),
        .ov_addr(addr[0]), .o_last(olast[0]), .o_zero(ozero[0])
    );

    bit_scan_encoder #(.WIDTH(5), .MSB_FIRST(1'b1)) u1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[1]), .o_ready(ord[1]),
        .iv_input(iv[4:0]), .o_valid(ov[1]), .i_ready(rdy),
        .ov_addr(addr[1]), .o_last(olast[1]), .o_zero(ozero[1])
    );

    bit_scan_encoder #(.WIDTH(8), .MSB_FIRST(1'b0)) u2 (
        .i_clk(clk), .i_rst(rst), .i_valid(vin[2]), .o_ready(ord[2]),
        .iv_input(iv), .o_valid(ov[2]), .i_ready(rdy),
        .ov_addr(addr[2]), .o_last(olast[2]), .o_zero(ozero[2])
    );

    typedef struct {
        int          d;
        logic [7:0]  v;
        int          mode;
        int          ign;
        int          n;
        logic [31:0] seq;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [7:0] v);
        int w;
        w = 0;
        while (!ord[d] && w < 20) begin
            tick();
            w++;
        end
        chk("send_ready", 32'(ord[d]), 32'd1);
        iv = v;
        vin[d] = 1'b1;
        tick();
        vin[d] = 1'b0;
        iv = 8'h00;
    endtask

    task automatic collect(input int d, input int mode, input int ign,
                           input int n, input logic [31:0] seq,
                           input int width);
        int k;
        int cyc;
        logic [2:0] held;
        logic hold;
        logic done;
        k = 0;
        cyc = 0;
        held = '0;
        hold = 1'b0;
        done = 1'b0;
        chk("first_valid", 32'(ov[d]), 32'd1);
        while (cyc < 40 && !done) begin
            rdy = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
            if (ign != 0) begin
                iv = 8'h02;
                vin[d] = ov[d];
            end
            if (hold) begin
                chk("hold_addr", 32'(addr[d]), 32'(held));
                chk("hold_valid", 32'(ov[d]), 32'd1);
            end
            hold = 1'b0;
            if (!ov[d]) begin
                done = 1'b1;
            end else begin
                chk("busy_not_ready", 32'(ord[d]), 32'd0);
                chk("addr_range", 32'(addr[d] < width), 32'd1);
                if (rdy) begin
                    chk("beat_addr", 32'(addr[d]), (seq >> (4 * k)) & 32'h7);
                    chk("beat_last", 32'(olast[d]), 32'(k == n - 1));
                    k++;
                    if (olast[d]) done = 1'b1;
                end else begin
                    held = addr[d];
                    hold = 1'b1;
                end
                tick();
                cyc++;
            end
        end
        vin[d] = 1'b0;
        iv = 8'h00;
        rdy = 1'b0;
        if (cyc >= 40) chk("collect_timeout", 32'd1, 32'd0);
        chk("beat_count", 32'(k), 32'(n));
        chk("post_ready", 32'(ord[d]), 32'd1);
        chk("post_valid", 32'(ov[d]), 32'd0);
    endtask

    initial begin
        tbl[0] = '{d: 0, v: 8'h16, mode: 0, ign: 0, n: 3, seq: 32'h421};
        tbl[1] = '{d: 1, v: 8'h16, mode: 0, ign: 0, n: 3, seq: 32'h124};
        tbl[2] = '{d: 1, v: 8'h01, mode: 0, ign: 0, n: 1, seq: 32'h0};
        tbl[3] = '{d: 2, v: 8'hFF, mode: 1, ign: 0, n: 8, seq: 32'h76543210};
        tbl[4] = '{d: 0, v: 8'h1F, mode: 0, ign: 1, n: 5, seq: 32'h43210};
        tbl[5] = '{d: 2, v: 8'hA5, mode: 0, ign: 0, n: 4, seq: 32'h7520};
        tbl[6] = '{d: 1, v: 8'h1F, mode: 1, ign: 0, n: 5, seq: 32'h01234};
        tbl[7] = '{d: 2, v: 8'h80, mode: 0, ign: 0, n: 1, seq: 32'h7};

        rst = 1'b1;
        vin = '0;
        iv = 8'h00;
        rdy = 1'b0;
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk("rst_valid", 32'(ov[d]), 32'd0);
            chk("rst_addr", 32'(addr[d]), 32'd0);
            chk("rst_last", 32'(olast[d]), 32'd0);
            chk("rst_zero", 32'(ozero[d]), 32'd0);
            chk("rst_ready_low", 32'(ord[d]), 32'd0);
        end
        rst = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("rst_ready_high", 32'(ord[d]), 32'd1);
        end

        for (int t = 0; t < 8; t++) begin
            send(tbl[t].d, tbl[t].v);
            collect(tbl[t].d, tbl[t].mode, tbl[t].ign, tbl[t].n,
                    tbl[t].seq, (tbl[t].d == 2) ? 8 : 5);
        end

        send(0, 8'h00);
        chk("zero_pulse", 32'(ozero[0]), 32'd1);
        chk("zero_no_valid", 32'(ov[0]), 32'd0);
        chk("zero_ready", 32'(ord[0]), 32'd1);
        tick();
        chk("zero_pulse_end", 32'(ozero[0]), 32'd0);
        chk("zero_no_valid2", 32'(ov[0]), 32'd0);
        chk("zero_ready2", 32'(ord[0]), 32'd1);

        send(2, 8'hA5);
        rdy = 1'b1;
        chk("mid_first_addr", 32'(addr[2]), 32'd0);
        chk("mid_first_valid", 32'(ov[2]), 32'd1);
        tick();
        chk("mid_second_addr", 32'(addr[2]), 32'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_ready_low", 32'(ord[2]), 32'd0);
        tick();
        chk("mid_rst_valid", 32'(ov[2]), 32'd0);
        chk("mid_rst_addr", 32'(addr[2]), 32'd0);
        chk("mid_rst_last", 32'(olast[2]), 32'd0);
        rst = 1'b0;
        rdy = 1'b0;
        #1;
        chk("mid_rst_ready_high", 32'(ord[2]), 32'd1);
        tick();
        chk("mid_rst_stays_idle", 32'(ov[2]), 32'd0);
        send(2, 8'h10);
        collect(2, 0, 0, 1, 32'h4, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
